dm_store_unit: RTL and testbench
================================

# dm_store_unit

Store-side counterpart of the load data extender: accepts sb/sh/sw requests from the MEM stage, generates byte enables and lane-replicated write data, and holds them in a 2-entry FIFO. The FIFO drains to the data-memory/bridge write port over a req/ack handshake. It sits between the MEM stage and the DM/bridge write interface. The pipeline stalls only when the FIFO is full.

## Interface
Parameters:
- DEPTH, 2, store buffer entries (power of two, ≥2)
- AW, 32, address width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  MEM stage presents a store this cycle
- storeType  input  2  00 sb, 01 sh, 10 sw, 11 reserved
- addr  input  AW  byte address of the store
- wdata  input  32  register data; low byte/half/word is significant
- st_ready  output  1  buffer can accept; equals !full
- ades  output  1  address-error-on-store flag (combinational; see Configuration)
- bus_req  output  1  head entry valid, write requested
- bus_addr  output  AW  word-aligned address {addr[AW-1:2],2'b00}
- bus_be  output  4  byte enables, bit i = byte lane i
- bus_wdata  output  32  lane-replicated write data
- bus_ack  input  1  write port consumed head entry this cycle
- empty  output  1  no pending stores (for sync/eret ordering)

## Operation
- Accept: st_valid & st_ready & legal storeType & !ades → push {bus_addr, be, data} at tail.
- Byte enables: sb → 4'b0001 << addr[1:0]; sh → addr[1] ? 4'b1100 : 4'b0011; sw → 4'b1111.
- Data: sb → {4{wdata[7:0]}}; sh → {2{wdata[15:0]}}; sw → wdata.
- storeType 11: not enqueued, no ades, no side effect.
- Head drives bus_req/bus_addr/bus_be/bus_wdata directly from storage; pop on bus_req & bus_ack.
- Occupancy counter 0..DEPTH; pointers wrap modulo DEPTH.
- Simultaneous push and pop: allowed when not full; count unchanged, both pointers advance.
- Full: st_ready=0; push ignored even if pop happens same cycle (no bypass; stall one cycle).
- Empty: bus_req=0; bus_addr/bus_be/bus_wdata don't-care but be forced 0 when !bus_req.
- Ordering: strictly FIFO; no merging, no reordering.
- Reset mid-operation: all pending entries discarded; writes already acked are not undone.

## Timing
- Reset values: st_ready=1, bus_req=0, bus_addr=0, bus_be=0, bus_wdata=0, empty=1, ades=0 when st_valid=0.
- Latency: store accepted at edge N → bus_req high in cycle N+1 (no combinational input→bus path).
- Bus outputs held stable while bus_req & !bus_ack; the initiator never retracts a request.
- Back-to-back: ack at edge M with second entry pending → next entry on bus in cycle M+1, giving sustained 1 store/cycle.
- st_ready and empty depend only on the registered count.
- ades is combinational from st_valid/storeType/addr, for use in the same cycle.

## Configuration
- STORE_MISALIGN_EXC_EN defined: ades = st_valid & ((sh & addr[0]) | (sw & addr[1:0]!=0)); the flagged store is not enqueued.
- Undefined: ades tied 0; the misaligned low bits are ignored. sh uses addr[1], and sw writes the aligned word.

## Structure
- Shared package (dm_pkg): storeType encodings ST_SB/ST_SH/ST_SW/ST_RSV, and BE constants BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100. Also houses the load-type encodings used by the load extender.
- Sub-module store_align: purely combinational storeType/addr/wdata → be/data/misalign. It is instantiated once ahead of the FIFO.
- FIFO storage, pointers and counter live in the top module.

## Test plan
- Reset, then sb addr=0x0000_1003 wdata=0x1234_56AB → cycle +1: bus_req=1, bus_addr=0x0000_1000, bus_be=4'b1000, bus_wdata=0xABAB_ABAB.
- sh addr=0x0000_2002 wdata=0xFFFF_BEEF with bus_ack tied 1 → bus_be=4'b1100, bus_wdata=0xBEEF_BEEF for exactly one cycle, then empty=1.
- With bus_ack=0, push three sw: the first two are accepted and st_ready=0 on the third. Raise ack for one cycle → st_ready=1, and the third is accepted on the next cycle. All three appear on the bus in order.
- Push and pop in the same cycle with count=1 → count stays 1, new entry at head after ack; no lost or duplicated write.
- With STORE_MISALIGN_EXC_EN, sw addr=0x0000_0006 → ades=1 same cycle, nothing enqueued, empty stays 1. Without the macro, same stimulus → bus_addr=0x0000_0004, bus_be=4'b1111.
- Reset asserted with 2 entries pending and bus_req=1 → next cycle bus_req=0, empty=1, st_ready=1; storeType=11 afterwards → no enqueue.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared data-memory encodings for the store unit and the load extender
package dm_pkg;
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;
  localparam logic [2:0] LT_LB = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW = 3'b100;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
endpackage

// File: rtl/dm_store_unit_store_align.sv
// store_align: storeType/addr/wdata -> byte enables, lane-replicated data, misalign (STORE_MISALIGN_EXC_EN)
module store_align
  import dm_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        legal,
  output logic        misalign
);
  always_comb begin
    be = store_type == ST_SB ? 4'b0001 << addr_lo :
         store_type == ST_SH ? (addr_lo[1] ? BE_HALF_HI : BE_HALF_LO) :
         store_type == ST_SW ? BE_WORD : 4'b0000;
    data = store_type == ST_SB ? {4{wdata[7:0]}} :
           store_type == ST_SH ? {2{wdata[15:0]}} : wdata;
    legal = store_type != ST_RSV;
`ifdef STORE_MISALIGN_EXC_EN
    misalign = (store_type == ST_SH && addr_lo[0]) || (store_type == ST_SW && addr_lo != 2'b00);
`else
    misalign = 1'b0;
`endif
  end
endmodule

// File: rtl/dm_store_unit.sv
// dm_store_unit: sb/sh/sw store buffer (DEPTH-entry FIFO) draining to the DM write port; ades gated by STORE_MISALIGN_EXC_EN
module dm_store_unit
  import dm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    storeType,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          st_ready,
  output logic          ades,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] r_addr [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic [3:0]    w_be;
  logic [31:0]   w_data;
  logic          w_legal, w_mis, w_push, w_pop;
  store_align u_align (
    .store_type(storeType),
    .addr_lo(addr[1:0]),
    .wdata(wdata),
    .be(w_be),
    .data(w_data),
    .legal(w_legal),
    .misalign(w_mis)
  );
  assign ades = st_valid & w_mis;
  assign st_ready = r_count != CW'(DEPTH);
  assign empty = r_count == '0;
  assign bus_req = !empty;
  assign bus_addr = bus_req ? r_addr[r_rd] : '0;
  assign bus_be = bus_req ? r_be[r_rd] : '0;
  assign bus_wdata = bus_req ? r_data[r_rd] : '0;
  assign w_push = st_valid & st_ready & w_legal & !ades;
  assign w_pop = bus_req & bus_ack;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wr] <= {addr[AW-1:2], 2'b00};
        r_be[r_wr] <= w_be;
        r_data[r_wr] <= w_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_dm_store_unit.sv
// tb_dm_store_unit: directed self-checking bench for dm_store_unit
module tb_dm_store_unit;
  logic        clk = 0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  storeType;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        st_ready;
  logic        ades;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        empty;
  int errors = 0;
  int checks = 0;
  dm_store_unit #(.DEPTH(2), .AW(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .storeType(storeType),
    .addr(addr), .wdata(wdata), .st_ready(st_ready), .ades(ades),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    storeType = t;
    addr = a;
    wdata = d;
    #1;
  endtask
  task automatic test_reset;
    reset = 1;
    bus_ack = 0;
    drive(0, 2'b00, 0, 0);
    tick;
    tick;
    reset = 0;
    #1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
    checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus_be got=%b exp=0000", bus_be); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (ades !== 1'b0) begin errors++; $display("FAIL reset_ades got=%b exp=0", ades); end
  endtask
  task automatic test_sb;
    drive(1, 2'b00, 32'h0000_1003, 32'h1234_56AB);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sb_no_comb_path got=%b exp=0", bus_req); end
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL sb_bus_req got=%b exp=1", bus_req); end
    checks++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_bus_addr got=%h exp=00001000", bus_addr); end
    checks++; if (bus_be !== 4'b1000) begin errors++; $display("FAIL sb_bus_be got=%b exp=1000", bus_be); end
    checks++; if (bus_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_bus_wdata got=%h exp=ababab ab", bus_wdata); end
    tick;
    checks++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_hold_addr got=%h exp=00001000", bus_addr); end
    bus_ack = 1;
    tick;
    bus_ack = 0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_drained got=%b exp=1", empty); end
  endtask
  task automatic test_sh_ack;
    bus_ack = 1;
    drive(1, 2'b01, 32'h0000_2002, 32'hFFFF_BEEF);
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL sh_bus_req got=%b exp=1", bus_req); end
    checks++; if (bus_be !== 4'b1100) begin errors++; $display("FAIL sh_bus_be got=%b exp=1100", bus_be); end
    checks++; if (bus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_bus_wdata got=%h exp=beefbeef", bus_wdata); end
    checks++; if (bus_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_bus_addr got=%h exp=00002000", bus_addr); end
    tick;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sh_one_cycle_empty got=%b exp=1", empty); end
    checks++; if (bus_be !== 4'b0000) begin errors++; $display("FAIL sh_be_forced0 got=%b exp=0000", bus_be); end
    bus_ack = 0;
    drive(1, 2'b01, 32'h0000_3000, 32'h0000_1234);
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_be !== 4'b0011) begin errors++; $display("FAIL sh_lo_be got=%b exp=0011", bus_be); end
    checks++; if (bus_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_lo_wdata got=%h exp=12341234", bus_wdata); end
    bus_ack = 1;
    tick;
    bus_ack = 0;
  endtask
  task automatic test_full;
    drive(1, 2'b10, 32'h0000_0100, 32'h1111_1111);
    tick;
    drive(1, 2'b10, 32'h0000_0104, 32'h2222_2222);
    tick;
    drive(1, 2'b10, 32'h0000_0108, 32'h3333_3333);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready got=%b exp=0", st_ready); end
    checks++; if (bus_addr !== 32'h0000_0100) begin errors++; $display("FAIL full_head0 got=%h exp=00000100", bus_addr); end
    bus_ack = 1;
    tick;
    bus_ack = 0;
    #1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_ack got=%b exp=1", st_ready); end
    checks++; if (bus_addr !== 32'h0000_0104) begin errors++; $display("FAIL full_head1 got=%h exp=00000104", bus_addr); end
    checks++; if (bus_wdata !== 32'h2222_2222) begin errors++; $display("FAIL full_head1_data got=%h exp=22222222", bus_wdata); end
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_third_taken got=%b exp=0", st_ready); end
    bus_ack = 1;
    tick;
    checks++; if (bus_addr !== 32'h0000_0108) begin errors++; $display("FAIL full_head2 got=%h exp=00000108", bus_addr); end
    checks++; if (bus_wdata !== 32'h3333_3333) begin errors++; $display("FAIL full_head2_data got=%h exp=33333333", bus_wdata); end
    tick;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", empty); end
    bus_ack = 0;
  endtask
  task automatic test_push_pop;
    drive(1, 2'b10, 32'h0000_0200, 32'hAAAA_0001);
    tick;
    drive(1, 2'b10, 32'h0000_0204, 32'hAAAA_0002);
    bus_ack = 1;
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL pp_bus_req got=%b exp=1", bus_req); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL pp_count1_ready got=%b exp=1", st_ready); end
    checks++; if (bus_addr !== 32'h0000_0204) begin errors++; $display("FAIL pp_head got=%h exp=00000204", bus_addr); end
    checks++; if (bus_wdata !== 32'hAAAA_0002) begin errors++; $display("FAIL pp_data got=%h exp=aaaa0002", bus_wdata); end
    tick;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_no_dup got=%b exp=1", empty); end
    bus_ack = 0;
  endtask
  task automatic test_misalign;
    drive(1, 2'b10, 32'h0000_0006, 32'hCAFE_F00D);
`ifdef STORE_MISALIGN_EXC_EN
    checks++; if (ades !== 1'b1) begin errors++; $display("FAIL mis_ades got=%b exp=1", ades); end
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mis_not_enqueued got=%b exp=1", empty); end
`else
    checks++; if (ades !== 1'b0) begin errors++; $display("FAIL mis_ades got=%b exp=0", ades); end
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_addr !== 32'h0000_0004) begin errors++; $display("FAIL mis_bus_addr got=%h exp=00000004", bus_addr); end
    checks++; if (bus_be !== 4'b1111) begin errors++; $display("FAIL mis_bus_be got=%b exp=1111", bus_be); end
    checks++; if (bus_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_bus_wdata got=%h exp=cafef00d", bus_wdata); end
    bus_ack = 1;
    tick;
    bus_ack = 0;
`endif
  endtask
  task automatic test_reset_mid;
    drive(1, 2'b00, 32'h0000_0040, 32'h0000_0055);
    tick;
    drive(1, 2'b00, 32'h0000_0041, 32'h0000_0066);
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (bus_req !== 1'b1 || st_ready !== 1'b0) begin errors++; $display("FAIL rm_prefill got=%b%b exp=10", bus_req, st_ready); end
    reset = 1;
    tick;
    reset = 0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rm_bus_req got=%b exp=0", bus_req); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty got=%b exp=1", empty); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rm_st_ready got=%b exp=1", st_ready); end
    drive(1, 2'b11, 32'h0000_0001, 32'hDEAD_BEEF);
    checks++; if (ades !== 1'b0) begin errors++; $display("FAIL rsv_ades got=%b exp=0", ades); end
    tick;
    drive(0, 2'b00, 0, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rsv_not_enqueued got=%b exp=1", empty); end
  endtask
  initial begin
    test_reset;
    test_sb;
    test_sh_ack;
    test_full;
    test_push_pop;
    test_misalign;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
